// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order pixel stream.
// Even-row pair maxima wait in a half-row line buffer for the matching odd row.
module max_pool_2x2 #(
    parameter int In_d_W = 18,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    input  logic [In_d_W-1:0] in_data,
    output logic              out_valid,
    output logic [In_d_W-1:0] out_data,
    output logic              frame_done
);

    localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = (IMG_W > 2) ? $clog2(LB_D) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    function automatic logic [In_d_W-1:0] smax(input logic [In_d_W-1:0] a,
                                               input logic [In_d_W-1:0] b);
        if ($signed(a) >= $signed(b)) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [In_d_W-1:0] h_q, h_d;
    logic [In_d_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [In_d_W-1:0] lbuf_q [LB_D];

    logic [LB_AW-1:0]  lb_idx_s;
    logic [In_d_W-1:0] pair_s;
    logic              lb_we_s;

    // Next-state logic: counters, horizontal hold, line-buffer write and output.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we_s      = 1'b0;
        lb_idx_s     = LB_AW'(col_q >> 1);
        pair_s       = smax(h_q, in_data);
        if (in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + ROW_ONE;
                end
            end else begin
                col_d = col_q + COL_ONE;
            end
            if (!col_q[0]) begin
                h_d = in_data;
            end else if (!row_q[0]) begin
                lb_we_s = 1'b1;
            end else begin
                out_data_d   = smax(lbuf_q[lb_idx_s], pair_s);
                out_valid_d  = 1'b1;
                frame_done_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
            end
        end else begin
            lb_we_s = 1'b0;
        end
    end

    // Control and output registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            h_q          <= {In_d_W{1'b0}};
            out_data_q   <= {In_d_W{1'b0}};
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer is never read before being rewritten in a frame, so it is not cleared.
    always_ff @(posedge clk) begin
        if (clr_n && lb_we_s) begin
            lbuf_q[lb_idx_s] <= pair_s;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: 4x4 instance for the directed scenarios,
// 28x28 instance for a randomised full-frame run against a reference max-pool.
module tb_max_pool_2x2;

    logic              clk = 1'b0;
    logic              clr_n, clr2_n;
    logic              in_valid, in2_valid;
    logic [17:0]       in_data, in2_data;
    logic              out_valid, out2_valid;
    logic [17:0]       out_data, out2_data;
    logic              frame_done, frame2_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [17:0] cap_data[$];
    int                 cap_cyc[$];
    int                 fd_cyc[$];
    logic signed [17:0] cyc_data[$];
    int                 cyc;

    always #5 clk = ~clk;

    max_pool_2x2 #(.In_d_W(18), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done)
    );

    max_pool_2x2 #(.In_d_W(18), .IMG_W(28), .IMG_H(28)) dut28 (
        .clk(clk), .clr_n(clr2_n), .in_valid(in2_valid), .in_data(in2_data),
        .out_valid(out2_valid), .out_data(out2_data), .frame_done(frame2_done)
    );

    task automatic clear_capture();
        cap_data.delete();
        cap_cyc.delete();
        fd_cyc.delete();
        cyc_data.delete();
        cyc = 0;
    endtask

    // One clock on the 4x4 instance; records what is visible after the edge.
    task automatic beat(input logic v, input logic [17:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        cyc_data.push_back(out_data);
        if (out_valid) begin
            cap_data.push_back(out_data);
            cap_cyc.push_back(cyc);
        end
        if (frame_done) fd_cyc.push_back(cyc);
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clr_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 18'd99;
        @(posedge clk);
        #1;
        @(negedge clk);
        clr_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({out_valid, frame_done, out_data} !== {1'b0, 1'b0, 18'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b fd=%b d=%0d, want 0 0 0", out_valid, frame_done, out_data);
        end
    endtask

    task automatic test_continuous();
        int exp_c[4] = '{5, 7, 13, 15};
        clear_capture();
        for (int i = 0; i < 16; i++) beat(1'b1, 18'(i));
        beat(1'b0, 18'd0);
        n_tests++;
        if (cap_data.size() != 4 || fd_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL cont_count: got %0d outs %0d fd, want 4 1", cap_data.size(), fd_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (cap_data[i] !== 18'(exp_c[i]) || cap_cyc[i] != exp_c[i]) begin
                    n_fail++;
                    $display("FAIL cont_out%0d: got %0d@%0d, want %0d@%0d", i, cap_data[i], cap_cyc[i], exp_c[i], exp_c[i]);
                end
            end
            n_tests++;
            if (fd_cyc[0] != 15) begin
                n_fail++;
                $display("FAIL cont_fd: got cycle %0d, want 15", fd_cyc[0]);
            end
        end
    endtask

    task automatic test_gaps();
        int exp_d[4] = '{5, 7, 13, 15};
        int exp_c[4] = '{10, 14, 26, 30};
        clear_capture();
        for (int i = 0; i < 16; i++) begin
            beat(1'b1, 18'(i));
            beat(1'b0, 18'd77);
        end
        n_tests++;
        if (cap_data.size() != 4 || fd_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL gap_count: got %0d outs %0d fd, want 4 1", cap_data.size(), fd_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (cap_data[i] !== 18'(exp_d[i]) || cap_cyc[i] != exp_c[i]) begin
                    n_fail++;
                    $display("FAIL gap_out%0d: got %0d@%0d, want %0d@%0d", i, cap_data[i], cap_cyc[i], exp_d[i], exp_c[i]);
                end
            end
            n_tests++;
            if (fd_cyc[0] != 30) begin
                n_fail++;
                $display("FAIL gap_fd: got cycle %0d, want 30", fd_cyc[0]);
            end
        end
        n_tests++;
        if (cyc_data[13] !== 18'sd5 || cyc_data[29] !== 18'sd13) begin
            n_fail++;
            $display("FAIL gap_hold: got %0d,%0d, want 5,13", cyc_data[13], cyc_data[29]);
        end
    endtask

    task automatic test_signed();
        logic signed [17:0] px[16];
        logic signed [17:0] exp_a[4];
        for (int i = 0; i < 16; i++) px[i] = 18'sd0;
        px[0] = -18'sd5; px[1] = -18'sd3; px[4] = -18'sd8; px[5] = -18'sd1;
        exp_a[0] = -18'sd1; exp_a[1] = 18'sd0; exp_a[2] = 18'sd0; exp_a[3] = 18'sd0;
        clear_capture();
        for (int i = 0; i < 16; i++) beat(1'b1, px[i]);
        n_tests++;
        if (cap_data.size() != 4) begin
            n_fail++;
            $display("FAIL neg_count: got %0d, want 4", cap_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (cap_data[i] !== exp_a[i]) begin
                    n_fail++;
                    $display("FAIL neg_out%0d: got %0d, want %0d", i, cap_data[i], exp_a[i]);
                end
            end
        end
        clear_capture();
        for (int i = 0; i < 16; i++) beat(1'b1, 18'h20000);
        n_tests++;
        if (cap_data.size() != 4) begin
            n_fail++;
            $display("FAIL min_count: got %0d, want 4", cap_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (cap_data[i] !== -18'sd131072) begin
                    n_fail++;
                    $display("FAIL min_out%0d: got %0d, want -131072", i, cap_data[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_d[8] = '{5, 7, 13, 15, 15, 13, 7, 5};
        int exp_c[8] = '{5, 7, 13, 15, 21, 23, 29, 31};
        clear_capture();
        for (int i = 0; i < 16; i++) beat(1'b1, 18'(i));
        for (int i = 0; i < 16; i++) beat(1'b1, 18'(15 - i));
        beat(1'b0, 18'd0);
        n_tests++;
        if (cap_data.size() != 8 || fd_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outs %0d fd, want 8 2", cap_data.size(), fd_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (cap_data[i] !== 18'(exp_d[i]) || cap_cyc[i] != exp_c[i]) begin
                    n_fail++;
                    $display("FAIL b2b_out%0d: got %0d@%0d, want %0d@%0d", i, cap_data[i], cap_cyc[i], exp_d[i], exp_c[i]);
                end
            end
            n_tests++;
            if (fd_cyc[0] != 15 || fd_cyc[1] != 31) begin
                n_fail++;
                $display("FAIL b2b_fd: got %0d,%0d, want 15,31", fd_cyc[0], fd_cyc[1]);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int exp_c[4] = '{5, 7, 13, 15};
        for (int i = 0; i < 6; i++) beat(1'b1, 18'(100 + i));
        apply_reset();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 18'd0) begin
            n_fail++;
            $display("FAIL mrst_state: got v=%b d=%0d, want 0 0", out_valid, out_data);
        end
        clear_capture();
        for (int i = 0; i < 16; i++) beat(1'b1, 18'(i));
        n_tests++;
        if (cyc_data[0] !== 18'sd0) begin
            n_fail++;
            $display("FAIL mrst_after: got %0d, want 0", cyc_data[0]);
        end
        n_tests++;
        if (cap_data.size() != 4 || fd_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL mrst_count: got %0d outs %0d fd, want 4 1", cap_data.size(), fd_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (cap_data[i] !== 18'(exp_c[i]) || cap_cyc[i] != exp_c[i]) begin
                    n_fail++;
                    $display("FAIL mrst_out%0d: got %0d@%0d, want %0d@%0d", i, cap_data[i], cap_cyc[i], exp_c[i], exp_c[i]);
                end
            end
        end
    endtask

    task automatic test_full_28();
        logic signed [17:0] px[784];
        logic signed [17:0] exp_q[196];
        logic signed [17:0] m;
        int n_out = 0;
        int n_fd = 0;
        int fd_ok = 0;
        for (int i = 0; i < 784; i++) px[i] = 18'($urandom);
        px[0] = 18'h20000; px[29] = 18'h1FFFF; px[30] = -18'sd1;
        for (int wr = 0; wr < 14; wr++) begin
            for (int wc = 0; wc < 14; wc++) begin
                m = px[(2 * wr) * 28 + 2 * wc];
                if (px[(2 * wr) * 28 + 2 * wc + 1] > m) m = px[(2 * wr) * 28 + 2 * wc + 1];
                if (px[(2 * wr + 1) * 28 + 2 * wc] > m) m = px[(2 * wr + 1) * 28 + 2 * wc];
                if (px[(2 * wr + 1) * 28 + 2 * wc + 1] > m) m = px[(2 * wr + 1) * 28 + 2 * wc + 1];
                exp_q[wr * 14 + wc] = m;
            end
        end
        @(negedge clk);
        clr2_n = 1'b0;
        @(negedge clk);
        clr2_n = 1'b1;
        for (int i = 0; i < 784; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                @(negedge clk);
                in2_valid = 1'b0;
                @(posedge clk);
                #1;
                n_tests++;
                if (out2_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL f28_idle: got out_valid=%b on idle beat, want 0", out2_valid);
                end
            end
            @(negedge clk);
            in2_valid = 1'b1;
            in2_data  = px[i];
            @(posedge clk);
            #1;
            if (out2_valid) begin
                n_tests++;
                if (n_out >= 196 || out2_data !== exp_q[n_out]) begin
                    n_fail++;
                    $display("FAIL f28_out%0d: got %0d, want %0d", n_out, $signed(out2_data),
                             (n_out < 196) ? exp_q[n_out] : 18'sd0);
                end
                n_out++;
            end
            if (frame2_done) begin
                n_fd++;
                if (out2_valid && n_out == 196) fd_ok = 1;
            end
        end
        @(negedge clk);
        in2_valid = 1'b0;
        n_tests++;
        if (n_out != 196 || n_fd != 1 || fd_ok != 1) begin
            n_fail++;
            $display("FAIL f28_totals: got %0d outs %0d fd coincident=%0d, want 196 1 1", n_out, n_fd, fd_ok);
        end
    endtask

    initial begin
        clr_n     = 1'b1;
        clr2_n    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 18'd0;
        in2_valid = 1'b0;
        in2_data  = 18'd0;
        test_reset();
        test_continuous();
        test_gaps();
        test_signed();
        test_back_to_back();
        test_midframe_reset();
        test_full_28();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
